// File: rtl/std_spram_banked.sv
// Banked single-port SRAM wrapper: byte strobes, valid/ready request port, tagged read path.
// Optional post-reset zero-fill is built when RAM_ZERO_INIT_EN is defined.
module std_spram_banked #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned OUT_REG   = 0,
  localparam int unsigned ADDR_W   = $clog2(DEPTH),
  localparam int unsigned STRB_W   = DATA_W / 8,
  localparam int unsigned BANK_D   = DEPTH / NUM_BANKS,
  localparam int unsigned BANK_AW  = $clog2(BANK_D),
  localparam int unsigned BSEL_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
);

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_READY} state_t;

  state_t                          r_state;
  logic                            r_init_done;
  logic                            w_init_we;
  logic [BANK_AW-1:0]              w_init_addr;
  logic                            w_acc;
  logic                            w_rd_acc;
  logic [BSEL_W-1:0]               w_bank;
  logic [BANK_AW-1:0]              w_baddr;
  logic [NUM_BANKS-1:0][DATA_W-1:0] w_bank_q;
  logic [DATA_W-1:0]               w_mux;
  logic                            r_rd_vld;
  logic [BSEL_W-1:0]               r_rd_tag;

`ifdef RAM_ZERO_INIT_EN
  logic [BANK_AW-1:0] r_init_cnt;
  assign w_init_we   = (r_state == ST_INIT);
  assign w_init_addr = r_init_cnt;
`else
  assign w_init_we   = 1'b0;
  assign w_init_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RESET;
      r_init_done <= 1'b0;
`ifdef RAM_ZERO_INIT_EN
      r_init_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        ST_RESET: begin
`ifdef RAM_ZERO_INIT_EN
          r_state     <= ST_INIT;
`else
          r_state     <= ST_READY;
          r_init_done <= 1'b1;
`endif
        end
        ST_INIT: begin
`ifdef RAM_ZERO_INIT_EN
          if (r_init_cnt == BANK_AW'(BANK_D - 1)) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end else begin
            r_init_cnt  <= r_init_cnt + 1'b1;
          end
`else
          r_state     <= ST_READY;
          r_init_done <= 1'b1;
`endif
        end
        default: begin
          r_state     <= ST_READY;
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  // A handshake coinciding with rst is dropped so nothing lands in the array or pipeline.
  assign w_acc    = req_valid & r_init_done & ~rst;
  assign w_rd_acc = w_acc & ~req_wen;
  assign w_baddr  = req_addr[BANK_AW-1:0];

  generate
    if (NUM_BANKS > 1) begin : g_bsel
      assign w_bank = req_addr[ADDR_W-1 -: BSEL_W];
    end else begin : g_bsel1
      assign w_bank = '0;
    end
  endgenerate

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_W-1:0] r_mem [BANK_D];
      logic [DATA_W-1:0] r_q;
      logic              w_sel;

      assign w_sel = w_acc && (w_bank == BSEL_W'(b));

      always_ff @(posedge clk) begin
        if (w_init_we && !rst) begin
          r_mem[w_init_addr] <= '0;
        end else if (w_sel) begin
          if (req_wen) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
              if (req_wstrb[i]) r_mem[w_baddr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
          end else begin
            r_q <= r_mem[w_baddr];
          end
        end
      end

      assign w_bank_q[b] = r_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_rd_vld <= 1'b0;
    else     r_rd_vld <= w_rd_acc;
    if (w_rd_acc) r_rd_tag <= w_bank;
  end

  // Mux on the registered tag so back-to-back reads across banks stay aligned.
  assign w_mux = w_bank_q[r_rd_tag];

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              r_rsp_vld;
      logic [DATA_W-1:0] r_rsp_data;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rsp_vld  <= 1'b0;
          r_rsp_data <= '0;
        end else begin
          r_rsp_vld <= r_rd_vld;
          if (r_rd_vld) r_rsp_data <= w_mux;
        end
      end
      assign rsp_valid = r_rsp_vld;
      assign rsp_rdata = r_rsp_data;
    end else begin : g_nreg
      assign rsp_valid = r_rd_vld;
      assign rsp_rdata = w_mux;
    end
  endgenerate

  assign req_ready = r_init_done;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_std_spram_banked.sv
// Scoreboard bench for std_spram_banked: OUT_REG=0 and OUT_REG=1 instances share one stimulus.
module tb_std_spram_banked;
  localparam int unsigned DW = 128;
`ifdef RAM_ZERO_INIT_EN
  localparam int unsigned INIT_LAT = 1024 / 2 + 1;
`else
  localparam int unsigned INIT_LAT = 1;
`endif

  typedef struct {
    logic [DW-1:0] d;
    int unsigned   due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_wen = 1'b0;
  logic [9:0]    req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [15:0]   req_wstrb = '0;
  logic          req_ready0, req_ready1, rsp_valid0, rsp_valid1, init_done0, init_done1;
  logic [DW-1:0] rsp_rdata0, rsp_rdata1;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  std_spram_banked #(.DATA_W(128), .DEPTH(1024), .NUM_BANKS(2), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .init_done(init_done0));

  std_spram_banked #(.DATA_W(128), .DEPTH(1024), .NUM_BANKS(2), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .init_done(init_done1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever either instance presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp0 cyc=%0d got rdata=%h required no response", cyc, rsp_rdata0);
      end else begin
        e = q0.pop_front();
        if (rsp_rdata0 !== e.d || cyc != e.due) begin
          errors++;
          $display("FAIL rsp0 got rdata=%h at cyc %0d required %h at cyc %0d", rsp_rdata0, cyc, e.d, e.due);
        end
      end
    end
    if (q0.size() > 0 && q0[0].due < cyc) begin
      e = q0.pop_front();
      checks++; errors++;
      $display("FAIL missing_rsp0 got no rsp_valid required %h at cyc %0d", e.d, e.due);
    end
    if (rsp_valid1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp1 cyc=%0d got rdata=%h required no response", cyc, rsp_rdata1);
      end else begin
        e = q1.pop_front();
        if (rsp_rdata1 !== e.d || cyc != e.due) begin
          errors++;
          $display("FAIL rsp1 got rdata=%h at cyc %0d required %h at cyc %0d", rsp_rdata1, cyc, e.d, e.due);
        end
      end
    end
    if (q1.size() > 0 && q1[0].due < cyc) begin
      e = q1.pop_front();
      checks++; errors++;
      $display("FAIL missing_rsp1 got no rsp_valid required %h at cyc %0d", e.d, e.due);
    end
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic do_write(input logic [9:0] a, input logic [DW-1:0] d, input logic [15:0] s);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, input logic [DW-1:0] e, input bit both);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = a; req_wstrb = '0;
    q0.push_back('{e, cyc + 1});
    if (both) q1.push_back('{e, cyc + 2});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int unsigned n = 0;
    while (init_done0 !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, DW'(n), DW'(INIT_LAT));
    check({name, "_ready1"}, DW'(req_ready1), DW'(1));
    check({name, "_ready_eq_done"}, DW'(req_ready0), DW'(init_done0));
  endtask

  localparam logic [DW-1:0] D5   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] VA   = {16{8'h11}};
  localparam logic [DW-1:0] VB   = {16{8'h22}};
  localparam logic [DW-1:0] VC   = {16{8'h3C}};
  localparam logic [DW-1:0] PART = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_55555555;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", DW'(req_ready0), DW'(0));
    check("rst_done1", DW'(init_done1), DW'(0));
    check("rst_valid0", DW'(rsp_valid0), DW'(0));
    check("rst_valid1", DW'(rsp_valid1), DW'(0));
    check("rst_rdata1", rsp_rdata1, '0);
    rst = 1'b0;
    wait_init("init");

`ifdef RAM_ZERO_INIT_EN
    do_read(10'h3FF, '0, 1'b1);
    do_read(10'h000, '0, 1'b1);
`endif
    do_write(10'h005, D5, 16'hFFFF);
    do_read(10'h005, D5, 1'b1);

    do_write(10'h010, {16{8'hAA}}, 16'hFFFF);
    do_write(10'h010, {16{8'h55}}, 16'h000F);
    do_read(10'h010, PART, 1'b1);

    do_write(10'h001, VA, 16'hFFFF);
    do_write(10'h201, VB, 16'hFFFF);
    do_read(10'h001, VA, 1'b1);
    do_read(10'h201, VB, 1'b1);
    do_read(10'h001, VA, 1'b1);

    do_write(10'h100, VC, 16'hFFFF);
    do_write(10'h100, {16{8'hFF}}, 16'h0000);
    do_read(10'h100, VC, 1'b1);

    do_write(10'h3FE, 128'h0, 16'hFFFF);
    do_write(10'h3FE, {16{8'hEE}}, 16'h8001);
    do_read(10'h3FE, 128'hEE000000_00000000_00000000_000000EE, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Read in flight on the registered-output instance when rst hits; only the OUT_REG=0 pulse survives.
    do_read(10'h005, D5, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_ready0", DW'(req_ready0), DW'(0));
    check("post_rst_ready1", DW'(req_ready1), DW'(0));
    check("post_rst_rdata1", rsp_rdata1, '0);
    wait_init("reinit");
`ifdef RAM_ZERO_INIT_EN
    do_read(10'h005, '0, 1'b1);
`else
    do_read(10'h005, D5, 1'b1);
    do_read(10'h201, VB, 1'b1);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("q0_drained", DW'(q0.size()), DW'(0));
    check("q1_drained", DW'(q1.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
